// File: rtl/koa_product_accumulator_if.sv
// Product stream in, accumulated result out.
// Two valid/ready handshakes bundled for the KOA accumulator.
interface koa_product_accumulator_if #(
    parameter int DATA_WIDTH  = 128,
    parameter int GUARD_BITS  = 8,
    parameter int COUNT_WIDTH = 9
);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + GUARD_BITS;

    logic [PROD_WIDTH-1:0]  product;
    logic                   product_valid;
    logic                   product_last;
    logic                   product_ready;
    logic [ACC_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0] acc_count;
    logic                   acc_overflow;
    logic                   acc_valid;
    logic                   acc_ready;

    modport master (
        output product, product_valid, product_last, acc_ready,
        input  product_ready, acc, acc_count, acc_overflow, acc_valid
    );

    modport slave (
        input  product, product_valid, product_last, acc_ready,
        output product_ready, acc, acc_count, acc_overflow, acc_valid
    );
endinterface

// File: rtl/koa_product_accumulator.sv
// Registered MAC back end for the KOA multiplier: sums product groups
// into a guard-extended accumulator and holds each result for the sink.
module koa_product_accumulator #(
    parameter int DATA_WIDTH  = 128,
    parameter int GUARD_BITS  = 8,
    parameter int COUNT_WIDTH = 9
) (
    input logic clk,
    input logic rst,
    koa_product_accumulator_if.slave bus
);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + GUARD_BITS;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic                   acc_ovf_q, acc_ovf_d;
    logic                   acc_valid_q, acc_valid_d;

    logic                   beat;
    logic [ACC_WIDTH:0]     sum_add;
    logic [COUNT_WIDTH-1:0] cnt_inc;

    assign bus.product_ready = (state_q != DRAIN);
    assign bus.acc           = acc_q;
    assign bus.acc_count     = acc_cnt_q;
    assign bus.acc_overflow  = acc_ovf_q;
    assign bus.acc_valid     = acc_valid_q;

    assign beat = bus.product_valid && (state_q != DRAIN);

    // Running state is zero in IDLE, so IDLE and ACCUM share one adder.
    assign sum_add = {1'b0, sum_q} + (ACC_WIDTH + 1)'(bus.product);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        acc_ovf_d   = acc_ovf_q;
        acc_valid_d = acc_valid_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (beat) begin
                    if (bus.product_last) begin
                        acc_d       = sum_add[ACC_WIDTH-1:0];
                        acc_cnt_d   = cnt_inc;
                        acc_ovf_d   = ovf_q | sum_add[ACC_WIDTH];
                        acc_valid_d = 1'b1;
                        sum_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = DRAIN;
                    end else begin
                        sum_d   = sum_add[ACC_WIDTH-1:0];
                        cnt_d   = cnt_inc;
                        ovf_d   = ovf_q | sum_add[ACC_WIDTH];
                        state_d = ACCUM;
                    end
                end
            end
            DRAIN: begin
                if (bus.acc_ready) begin
                    acc_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            acc_ovf_q   <= 1'b0;
            acc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_ovf_q   <= acc_ovf_d;
            acc_valid_q <= acc_valid_d;
        end
    end
endmodule

// File: tb/tb_koa_product_accumulator.sv
// Randomized and directed bench for koa_product_accumulator against
// a big-integer group-sum model.
module tb_koa_product_accumulator;
    localparam int DW = 128;
    localparam int GB = 8;
    localparam int CW = 9;
    localparam int PW = 2 * DW;
    localparam int AW = PW + GB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    koa_product_accumulator_if #(
        .DATA_WIDTH(DW), .GUARD_BITS(GB), .COUNT_WIDTH(CW)
    ) bus ();

    koa_product_accumulator #(
        .DATA_WIDTH(DW), .GUARD_BITS(GB), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] grp[$];

    task automatic check(input string tag,
                         input logic [AW-1:0] got,
                         input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact sum in a wider integer; overflow means the true total
    // does not fit in AW bits (sums only grow, so any beat == the end).
    function automatic void model(output logic [AW-1:0] ea,
                                  output logic [CW-1:0] ec,
                                  output logic eo);
        logic [AW+15:0] tot;
        int n;
        tot = '0;
        foreach (grp[i]) tot += (AW + 16)'(grp[i]);
        ea = tot[AW-1:0];
        eo = (tot >> AW) != 0;
        n  = grp.size();
        ec = (n > (1 << CW) - 1) ? '1 : CW'(n);
    endfunction

    function automatic logic [PW-1:0] rand_p();
        logic [PW-1:0] p;
        if ($urandom_range(0, 3) == 0) return '1;
        for (int k = 0; k < PW / 32; k++) p[k*32 +: 32] = $urandom;
        return p;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_beat(input logic [PW-1:0] p, input logic last);
        int  t;
        bit  done;
        t    = 0;
        done = 0;
        bus.product       = p;
        bus.product_valid = 1'b1;
        bus.product_last  = last;
        while (!done) begin
            done = bus.product_ready;
            @(posedge clk);
            t++;
            if (!done && t > 50) begin
                check("beat_timeout", 264'(bus.product_ready), 264'd1);
                done = 1;
            end
        end
        @(negedge clk);
    endtask

    // Called at the negedge right after the last beat was accepted.
    task automatic collect(input int stall);
        logic [AW-1:0] ea;
        logic [CW-1:0] ec;
        logic          eo;
        model(ea, ec, eo);
        check("valid_rise", 264'(bus.acc_valid), 264'd1);
        check("acc", bus.acc, ea);
        check("count", 264'(bus.acc_count), 264'(ec));
        check("ovf", 264'(bus.acc_overflow), 264'(eo));
        check("ready_drain", 264'(bus.product_ready), 264'd0);
        bus.acc_ready = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 264'(bus.acc_valid), 264'd1);
            check("stall_acc", bus.acc, ea);
            check("stall_ready", 264'(bus.product_ready), 264'd0);
            if (s == stall - 1) bus.acc_ready = 1'b1;
        end
        @(negedge clk);
        check("valid_fall", 264'(bus.acc_valid), 264'd0);
        check("ready_idle", 264'(bus.product_ready), 264'd1);
        check("acc_held", bus.acc, ea);
    endtask

    task automatic run_group(input int stall, input bit gaps);
        bus.acc_ready = 1'($urandom);
        for (int i = 0; i < grp.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.product_valid = 1'b0;
                bus.product_last  = 1'b1;
                bus.product       = '1;
                @(negedge clk);
            end
            send_beat(grp[i], i == grp.size() - 1);
        end
        bus.product_valid = 1'b0;
        bus.product_last  = 1'b0;
        collect(stall);
    endtask

    initial begin
        logic [PW-1:0] m;
        bus.product       = '0;
        bus.product_valid = 1'b0;
        bus.product_last  = 1'b0;
        bus.acc_ready     = 1'b0;
        rst               = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", 264'(bus.acc_valid), 264'd0);
        check("rst_acc", bus.acc, 264'd0);
        check("rst_count", 264'(bus.acc_count), 264'd0);
        check("rst_ovf", 264'(bus.acc_overflow), 264'd0);
        check("rst_ready", 264'(bus.product_ready), 264'd1);

        grp = {256'd1};
        run_group(0, 0);

        m = {DW{1'b1}};
        m = m * m;
        grp.delete();
        repeat (4) grp.push_back(m);
        run_group(0, 0);

        grp.delete();
        repeat (256) grp.push_back('1);
        run_group(0, 0);

        grp.delete();
        repeat (257) grp.push_back('1);
        run_group(1, 0);

        grp = {256'd3};
        run_group(0, 0);

        grp.delete();
        repeat (520) grp.push_back(256'd1);
        run_group(0, 0);

        // Backpressure: next beat waits upstream during the stall.
        grp = {256'd5, 256'd7};
        bus.acc_ready = 1'b1;
        send_beat(256'd5, 1'b0);
        send_beat(256'd7, 1'b1);
        bus.product       = 256'd9;
        bus.product_valid = 1'b1;
        bus.product_last  = 1'b1;
        bus.acc_ready     = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check("bp_valid", 264'(bus.acc_valid), 264'd1);
            check("bp_acc", bus.acc, 264'd12);
            check("bp_count", 264'(bus.acc_count), 264'd2);
            check("bp_ready", 264'(bus.product_ready), 264'd0);
            @(negedge clk);
        end
        bus.acc_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", 264'(bus.acc_valid), 264'd0);
        check("bp_hs_ready", 264'(bus.product_ready), 264'd1);
        @(negedge clk);
        bus.product_valid = 1'b0;
        bus.product_last  = 1'b0;
        grp = {256'd9};
        collect(0);

        // Reset in the middle of a group discards it.
        send_beat(256'd100, 1'b0);
        send_beat(256'd100, 1'b0);
        send_beat(256'd100, 1'b0);
        bus.product_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 264'(bus.acc_valid), 264'd0);
        check("mid_rst_ready", 264'(bus.product_ready), 264'd1);
        @(negedge clk);
        check("mid_rst_valid2", 264'(bus.acc_valid), 264'd0);
        grp = {256'd5};
        run_group(0, 0);

        for (int g = 0; g < 30; g++) begin
            int n;
            n = $urandom_range(1, 6);
            grp.delete();
            for (int i = 0; i < n; i++) grp.push_back(rand_p());
            run_group($urandom_range(0, 3), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/koa_product_accumulator.md
Name: koa_product_accumulator

Overview:
- Downstream consumer of the 128-bit Karatsuba multiplier. It takes a stream of 2*DATA_WIDTH-bit products over a valid/ready handshake.
- It sums each group of products, terminated by product_last, into a guard-extended accumulator. The finished sum, beat count and overflow flag are held until the sink accepts them.
- It is the registered multiply-accumulate back end that turns the combinational KOA product into dot-product / MAC results.

Parameters:
- DATA_WIDTH, 128, multiplier operand width; product width is 2*DATA_WIDTH.
- GUARD_BITS, 8, extra accumulator MSBs; ACC_WIDTH = 2*DATA_WIDTH + GUARD_BITS (264 at defaults).
- COUNT_WIDTH, 9, width of the per-group beat counter (GUARD_BITS+1 at defaults).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- product  input  2*DATA_WIDTH  product from KOA multiplier, unsigned.
- product_valid  input  1  product/product_last are valid this cycle.
- product_last  input  1  this beat closes the current group.
- product_ready  output  1  block can accept a beat this cycle.
- acc  output  ACC_WIDTH  finished group sum, unsigned, wraps modulo 2^ACC_WIDTH.
- acc_count  output  COUNT_WIDTH  number of beats in the finished group, saturating.
- acc_overflow  output  1  group sum exceeded 2^ACC_WIDTH-1 at any beat.
- acc_valid  output  1  acc/acc_count/acc_overflow are valid and held.
- acc_ready  input  1  sink accepts the result this cycle.

Behaviour:
- Reset (sync, active-high, one clk suffices):
  - state=IDLE; running sum, running count and sticky overflow cleared.
  - acc=0, acc_count=0, acc_overflow=0, acc_valid=0, product_ready=1 on the cycle after rst is sampled high.
- Reset mid-group or mid-drain: the partial sum and any held result are discarded with no output handshake. The next accepted beat starts a fresh group.
- A beat is accepted when product_valid && product_ready. acc is accepted when acc_valid && acc_ready.
- product_ready = (state != DRAIN), a combinational function of registered state only. There is no combinational path from acc_ready to product_ready.
- FSM:
  - IDLE: no beats held. Accepted beat, not last -> ACCUM with sum=zero-extended product, count=1. Accepted beat, last -> DRAIN.
  - ACCUM: each accepted beat adds: sum <= sum + product. Carry out of bit ACC_WIDTH-1 sets the sticky overflow; the sum keeps its low ACC_WIDTH bits. Count increments and saturates at 2^COUNT_WIDTH-1. Accepted last beat -> DRAIN.
  - DRAIN: output registers are loaded with the final sum, count and overflow, including the last beat's contribution. acc_valid=1 and product_ready=0. Outputs hold stable while acc_ready=0. On acc_ready -> IDLE with the running state cleared.
- Latency:
  - acc_valid rises on the cycle after the last beat is accepted.
  - acc_valid falls on the cycle after the output handshake.
  - Minimum group period is N+1 cycles for N beats; the DRAIN cycle is a one-cycle bubble even when acc_ready is held high.
- acc/acc_count/acc_overflow keep their last driven values after the handshake, with acc_valid=0. Only acc_valid qualifies them.
- product_valid with product_ready=0 is ignored. The upstream holds the beat and the block neither samples nor drops it.
- product_last with product_valid=0 is ignored.
- Overflow is per group: it clears when DRAIN exits. Count saturation does not itself set acc_overflow.

Test Plan:
- Reset: hold rst 2 cycles -> acc_valid=0, acc=0, acc_count=0, acc_overflow=0, product_ready=1.
- Single beat: product=1 with last -> next cycle acc_valid=1, acc=1, acc_count=1, acc_overflow=0. With acc_ready=1 -> acc_valid=0 the following cycle.
- Max-operand MAC: 4 beats of (2^128-1)^2 = 256'hFFFF...FFFE_0000...0001 (32 F's incl. the final E, then 32 hex digits ending in 1), last on beat 4 -> acc = 4*(2^128-1)^2, acc_count=4, acc_overflow=0.
- Guard boundary:
  - 256 beats of 2^256-1 -> acc=2^264-256, acc_count=256, acc_overflow=0.
  - 257 beats -> acc=2^256-257 (wrapped), acc_count=257, acc_overflow=1.
  - Next group of 1 beat of 3 -> acc=3, acc_overflow=0.
- Backpressure: after a 2-beat group of 5,7 hold acc_ready=0 for 5 cycles while product_valid=1 with product=9.
  - During the stall: acc=12 stable, product_ready=0, product 9 not consumed.
  - Then acc_ready=1 -> handshake, 9 accepted next group from zero.
- Reset mid-group: accept 3 beats of 100, pulse rst 1 cycle -> no acc_valid. Then single beat 5 with last -> acc=5, acc_count=1.
